// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS-subset control FSM for a shared-memory datapath.
// Outputs are a Moore decode of the state register; pc_en, plus the
// IF/MEMWR handshake gating when MEM_WAIT=1, also depend on live inputs.
module multicycle_ctrl_v2 #(
    parameter bit MEM_WAIT   = 1'b0,
    parameter bit EN_JAL     = 1'b1,
    parameter bit EN_BNE     = 1'b1,
    parameter bit EN_IMM_ALU = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [1:0] toaluctrl,
    output logic [1:0] pcsrc,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       IorD,
    output logic       IR_write,
    output logic       pc_write,
    output logic       pc_write_condition_beq,
    output logic       pc_write_condition_bne,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_JAL    = 4'd12
    } state_e;

    state_e state_q, state_d;
    logic   is_sw_q, is_sw_d;
    logic   is_bne_q, is_bne_d;
    logic   is_andi_q, is_andi_d;
    logic   op_legal;
    logic   mem_ok;

    // A memory access completes this cycle (always true for single-cycle memory).
    assign mem_ok = !MEM_WAIT || mem_ready;

    // Opcode legality, including the build-time feature enables.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_BNE:                               op_legal = EN_BNE;
            OP_JAL:                               op_legal = EN_JAL;
            OP_ADDI, OP_ANDI:                     op_legal = EN_IMM_ALU;
            default:                              op_legal = 1'b0;
        endcase
    end

    // State register and the sub-kind flags captured in ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            is_sw_q   <= 1'b0;
            is_bne_q  <= 1'b0;
            is_andi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            is_bne_q  <= is_bne_d;
            is_andi_q <= is_andi_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d                = state_q;
        is_sw_d                = is_sw_q;
        is_bne_d               = is_bne_q;
        is_andi_d              = is_andi_q;
        alusrcA                = 1'b0;
        alusrcB                = 2'b00;
        toaluctrl              = ALU_ADD;
        pcsrc                  = 2'b00;
        regdst                 = 2'b00;
        memtoreg               = 2'b00;
        memread                = 1'b0;
        memwrite               = 1'b0;
        regwrite               = 1'b0;
        IorD                   = 1'b0;
        IR_write               = 1'b0;
        pc_write               = 1'b0;
        pc_write_condition_beq = 1'b0;
        pc_write_condition_bne = 1'b0;
        instr_done             = 1'b0;
        illegal                = 1'b0;

        case (state_q)
            S_IF: begin
                memread  = 1'b1;
                alusrcB  = 2'b01;
                IR_write = mem_ok;
                pc_write = mem_ok;
                if (mem_ok) state_d = S_ID;
            end
            S_ID: begin
                // Branch target PC + (imm<<2) lands in ALUOut.
                alusrcB   = 2'b11;
                is_sw_d   = (opcode == OP_SW);
                is_bne_d  = (opcode == OP_BNE);
                is_andi_d = (opcode == OP_ANDI);
                if (!op_legal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_REXE;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = S_BR;
                end else if (opcode == OP_J) begin
                    state_d = S_JMP;
                end else if (opcode == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
                    state_d = S_IEXE;
                end
            end
            S_MEMADR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
                state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                IorD    = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 2'b01;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_MEMWR: begin
                memwrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ok;
                if (mem_ok) state_d = S_IF;
            end
            S_REXE: begin
                alusrcA   = 1'b1;
                toaluctrl = ALU_FUNC;
                state_d   = S_RWB;
            end
            S_RWB: begin
                regwrite   = 1'b1;
                regdst     = 2'b01;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_IEXE: begin
                alusrcA   = 1'b1;
                alusrcB   = 2'b10;
                toaluctrl = is_andi_q ? ALU_AND : ALU_ADD;
                state_d   = S_IWB;
            end
            S_IWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_BR: begin
                alusrcA                = 1'b1;
                toaluctrl              = ALU_SUB;
                pcsrc                  = 2'b01;
                pc_write_condition_beq = !is_bne_q;
                pc_write_condition_bne = is_bne_q;
                instr_done             = 1'b1;
                state_d                = S_IF;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pcsrc      = 2'b10;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pcsrc      = 2'b10;
                regwrite   = 1'b1;
                regdst     = 2'b10;
                memtoreg   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Qualified PC enable; zero only matters while a branch is resolving.
    assign pc_en = pc_write
                 | (pc_write_condition_beq & zero)
                 | (pc_write_condition_bne & ~zero);

    assign state = 4'(state_q);

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Parametrised multicycle MIPS-subset control FSM that drives the shared-memory datapath: PC, IR, MDR, A/B, ALUOut, register file, and a single memory port.
- Successor to the first-generation controller:
  - adds bne, jal, addi and andi;
  - adds an optional memory-ready wait handshake;
  - flags illegal opcodes;
  - generates the qualified PC enable internally.
- Sits between the IR opcode field and the datapath mux/enable inputs.

Parameters:
- MEM_WAIT, 0, 1 = IF/MEMRD/MEMWR states hold until mem_ready=1; 0 = mem_ready ignored, single-cycle memory.
- EN_JAL, 1, 1 = jal (000011) legal; 0 = treated as illegal.
- EN_BNE, 1, 1 = bne (000101) legal; 0 = treated as illegal.
- EN_IMM_ALU, 1, 1 = addi (001000) and andi (001100) legal; 0 = treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- opcode  in  6  IR[31:26]; sampled in ID only
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (used when MEM_WAIT=1)
- alusrcA  out  1  0=PC, 1=A
- alusrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- toaluctrl  out  2  00=add, 01=sub, 10=R-type funct, 11=and
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- regdst  out  2  00=rt, 01=rd, 10=$31
- memtoreg  out  2  00=ALUOut, 01=MDR, 10=PC
- memread, memwrite, regwrite, IorD, IR_write, pc_write  out  1 each  datapath enables/selects
- pc_write_condition_beq, pc_write_condition_bne  out  1 each  branch qualifiers
- pc_en  out  1  pc_write | (beq & zero) | (bne & ~zero)
- instr_done  out  1  pulse on the last cycle of every instruction
- illegal  out  1  pulse in ID when the decoded opcode is unsupported
- state  out  4  current state code, for debug

Behaviour:
- Outputs are a Moore decode of the state register. The only exceptions are pc_en (uses zero) and the MEM_WAIT gating described below. Any signal not listed for a state is 0.
- Reset: on the clk edge with reset=1, state <= IF (0). This applies mid-instruction too: no write completes afterwards.
- Output values after reset (IF decode): memread=1, IR_write=1, pc_write=1, alusrcB=01, pc_en=1. All other outputs are 0.
- State codes:
  - IF=0: memread, IorD=0, IR_write, alusrcA=0, alusrcB=01, add, pc_write, pcsrc=00.
  - ID=1: alusrcA=0, alusrcB=11, add. Branch target goes to ALUOut.
  - MEMADR=2: alusrcA=1, alusrcB=10, add.
  - MEMRD=3: memread, IorD=1.
  - MEMWB=4: regwrite, regdst=00, memtoreg=01, instr_done.
  - MEMWR=5: memwrite, IorD=1, instr_done.
  - REXE=6: alusrcA=1, alusrcB=00, toaluctrl=10.
  - RWB=7: regwrite, regdst=01, memtoreg=00, instr_done.
  - IEXE=8: alusrcA=1, alusrcB=10; toaluctrl=00 for addi, 11 for andi. The selection uses a 1-bit flag latched in ID.
  - IWB=9: regwrite, regdst=00, memtoreg=00, instr_done.
  - BR=10: alusrcA=1, alusrcB=00, sub, pcsrc=01, instr_done.
    - beq: pc_write_condition_beq=1.
    - bne: pc_write_condition_bne=1.
    - The beq/bne choice uses a 1-bit flag latched in ID.
  - JMP=11: pc_write, pcsrc=10, instr_done.
  - JAL=12: pc_write, pcsrc=10, regwrite, regdst=10, memtoreg=10, instr_done.
  - Codes 13-15 are unused; any of them -> IF on the next edge.
- Transitions:
  - IF -> ID.
  - ID branches on opcode:
    - lw (100011) and sw (101011) -> MEMADR.
    - R-type (000000) -> REXE.
    - beq (000100) and bne -> BR.
    - j (000010) -> JMP.
    - jal -> JAL.
    - addi and andi -> IEXE.
    - Anything else -> IF with illegal=1 for that cycle; no architectural write occurs.
  - MEMADR -> MEMRD (lw) or MEMWR (sw); the choice uses a flag latched in ID.
  - MEMRD -> MEMWB.
  - REXE -> RWB.
  - IEXE -> IWB.
  - MEMWB, MEMWR, RWB, IWB, BR, JMP, JAL -> IF.
  - Opcodes disabled by parameter are illegal.
- Latency in cycles with MEM_WAIT=0: lw 5, sw 4, R 4, addi/andi 4, beq/bne 3, j/jal 3.
- MEM_WAIT=1 handshake:
  - In IF, IR_write and pc_write are asserted only while mem_ready=1. The state holds in IF until mem_ready=1, then -> ID.
  - In MEMRD, the state holds until mem_ready=1, then -> MEMWB.
  - In MEMWR, memwrite stays asserted while waiting. instr_done and the advance to IF occur only in the cycle with mem_ready=1.
  - Every memory access adds exactly N cycles, where N is the number of cycles mem_ready is low.
  - mem_ready is ignored in all non-memory states.
- pc_en is combinational:
  - BR with beq and zero=1 -> 1.
  - BR with bne and zero=0 -> 1.
  - BR otherwise -> 0.
- The flags latched in ID (lw/sw, beq/bne, addi/andi) are cleared by reset.
- The opcode input is don't-care in every state except ID.

Test Plan:
- Reset mid-MEMRD, then release -> state=0 next cycle; memread=1, IR_write=1, pc_en=1; regwrite never pulses.
- lw (100011), MEM_WAIT=0 -> state sequence 0,1,2,3,4; MEMWB has regwrite=1, memtoreg=01, regdst=00, instr_done=1; back in IF at cycle 6.
- beq with zero=1, then bne with zero=1 -> BR pc_en=1 for beq, 0 for bne; both 3 cycles, pcsrc=01, toaluctrl=01.
- jal (000011) -> JAL state: pc_write=1, pcsrc=10, regdst=10, memtoreg=10, regwrite=1; EN_JAL=0 build -> illegal=1 in ID, then state=0.
- MEM_WAIT=1, sw with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles; instr_done only in the mem_ready=1 cycle; total 7 cycles.
- andi (001100) then addi (001000) -> IEXE toaluctrl=11 then 00; alusrcB=10; IWB regwrite with regdst=00.
